operand_reader: RTL and testbench
=================================

Name: operand_reader

Overview:
Reads a contiguous range of 64-bit memory words and unpacks each word into a pair of 32-bit operands for the ALU. The lower half of each word becomes operand A and the upper half becomes operand B. This is the read-side counterpart of the 64-bit result buffer, which packs ALU results into memory words. It sits between the memory read port and the ALU input, and presents operands through a valid/ready handshake.

Parameters:
DATA_W, 32, operand width; taken from calculator_pkg.
MEM_WORD_SIZE, 64, memory word width; equals 2*DATA_W; taken from calculator_pkg.
ADDR_W, 10, memory address width; taken from calculator_pkg.

Ports:
clk_i  input  1  clock; all state updates on posedge
rst_i  input  1  synchronous, active-high reset
start_i  input  1  one-cycle pulse that starts a read run
start_addr_i  input  ADDR_W  first word address; inclusive
end_addr_i  input  ADDR_W  last word address; inclusive
mem_rd_en_o  output  1  memory read strobe
mem_addr_o  output  ADDR_W  memory read address
mem_rdata_i  input  MEM_WORD_SIZE  read data; valid exactly 1 cycle after the cycle with mem_rd_en_o=1
op_a_o  output  DATA_W  operand A = word[DATA_W-1:0]
op_b_o  output  DATA_W  operand B = word[MEM_WORD_SIZE-1:DATA_W]
op_valid_o  output  1  operand pair valid
op_ready_i  input  1  ALU accepts the pair
busy_o  output  1  a run is in progress (state != S_IDLE)
done_o  output  1  one-cycle pulse at the end of a run
err_o  output  1  one-cycle pulse when a range is rejected (end < start)

Behaviour:
- Reset: when rst_i=1 at a posedge, the block enters S_IDLE and clears every output and internal register to 0. Reset has priority over all other inputs. It aborts a run in progress: no done_o pulse and no further reads.
- FSM states: S_IDLE, S_FETCH, S_CAPTURE, S_PRESENT, S_DONE.
- S_IDLE:
  - On start_i=1 with end_addr_i >= start_addr_i: latch cur_addr=start_addr_i and end_addr=end_addr_i, then go to S_FETCH.
  - On start_i=1 with end_addr_i < start_addr_i: pulse err_o for one cycle, pulse done_o in the same cycle, issue no reads and stay in S_IDLE.
- S_FETCH: mem_rd_en_o=1 and mem_addr_o=cur_addr for exactly one cycle, then go to S_CAPTURE.
- S_CAPTURE: latch mem_rdata_i into the word register, then go to S_PRESENT.
- S_PRESENT:
  - op_valid_o=1. op_a_o and op_b_o come from registers and stay stable while valid and not accepted.
  - Handshake completes in a cycle where op_valid_o=1 and op_ready_i=1.
  - On handshake with cur_addr==end_addr: go to S_DONE.
  - On handshake otherwise: cur_addr+1, then go to S_FETCH.
  - Without handshake: hold all outputs.
- S_DONE: done_o=1 for one cycle, then go to S_IDLE.
- mem_rd_en_o is 0 in every state except S_FETCH. mem_addr_o is 0 whenever mem_rd_en_o=0. op_valid_o is 0 in every state except S_PRESENT.
- start_i is ignored while busy_o=1.
- Latency: with start_i at cycle 0 and op_ready_i held at 1:
  - read at cycle 1
  - data captured at the cycle 2 edge; op_valid_o=1 at cycle 3
  - each word costs 3 cycles
  - done_o is high the cycle after the last handshake
- The address never wraps. end_addr = 2^ADDR_W-1 is legal, and the run stops there without incrementing past it.
- Operand registers keep their last values after a run; only reset clears them.

Decomposition:
- calculator_pkg holds DATA_W, MEM_WORD_SIZE and ADDR_W.
- calculator_pkg also holds the state enum typedef reader_state_t, so the top-level controller and the bench can decode state.
- One natural sub-module: word_unpacker. It contains the MEM_WORD_SIZE capture register with its load enable and the split into lower and upper DATA_W halves. The FSM and address counter stay in operand_reader.

Test Plan:
1. Single word: start=5, end=5, mem[5]=64'hDEAD_BEEF_0000_0001, op_ready_i=1 → exactly one read at addr 5; op_a=32'h0000_0001, op_b=32'hDEAD_BEEF; done_o pulses in the cycle after the handshake; busy_o=0 afterwards.
2. Range with backpressure: start=0, end=3, op_ready_i low for 4 cycles on word 1 → reads at addrs 0,1,2,3 in order; outputs stable while stalled; no read issued during the stall; exactly 4 handshakes.
3. Bad range: start=8, end=2 → err_o and done_o pulse once together; mem_rd_en_o never asserted; busy_o stays 0.
4. Mid-run reset: start=0, end=9, assert rst_i during S_PRESENT of word 4 → next cycle all outputs are 0 and state is S_IDLE; no done_o; a new start=0, end=0 then completes normally.
5. Top of address space: start=1022, end=1023 (ADDR_W=10) → reads at 1022 and 1023 only, no access to address 0, done_o pulses once.
6. start_i while busy: pulse start_i (start=50, end=50) during a run start=0, end=1 → ignored; only addrs 0 and 1 are read.

Source files
------------

// File: rtl/calculator_pkg.sv
// Shared widths and state encoding for the calculator datapath blocks.
// The operand reader and its bench both decode reader_state_t from here.
package calculator_pkg;

   localparam int DATA_W        = 32;
   localparam int MEM_WORD_SIZE = 2 * DATA_W;
   localparam int ADDR_W        = 10;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_FETCH   = 3'd1,
      S_CAPTURE = 3'd2,
      S_PRESENT = 3'd3,
      S_DONE    = 3'd4
   } reader_state_t;

endpackage

// File: rtl/operand_reader_if.sv
// Bus bundle for the operand reader: run control, memory read port,
// operand handshake toward the ALU and run status.
interface operand_reader_if;
   import calculator_pkg::*;

   logic                     start_i;
   logic [ADDR_W-1:0]        start_addr_i;
   logic [ADDR_W-1:0]        end_addr_i;
   logic                     mem_rd_en_o;
   logic [ADDR_W-1:0]        mem_addr_o;
   logic [MEM_WORD_SIZE-1:0] mem_rdata_i;
   logic [DATA_W-1:0]        op_a_o;
   logic [DATA_W-1:0]        op_b_o;
   logic                     op_valid_o;
   logic                     op_ready_i;
   logic                     busy_o;
   logic                     done_o;
   logic                     err_o;

   // Driver side: issues runs, supplies memory data, accepts operands.
   modport master (
      output start_i, start_addr_i, end_addr_i, mem_rdata_i, op_ready_i,
      input  mem_rd_en_o, mem_addr_o, op_a_o, op_b_o, op_valid_o,
             busy_o, done_o, err_o
   );

   // Reader side: the operand_reader itself.
   modport slave (
      input  start_i, start_addr_i, end_addr_i, mem_rdata_i, op_ready_i,
      output mem_rd_en_o, mem_addr_o, op_a_o, op_b_o, op_valid_o,
             busy_o, done_o, err_o
   );

endinterface

// File: rtl/operand_reader_word_unpacker.sv
// Holds one captured memory word and splits it into the two operands.
// Lower half is operand A, upper half is operand B.
module word_unpacker
   import calculator_pkg::*;
(
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic [MEM_WORD_SIZE-1:0] word_in,
   output logic [DATA_W-1:0]        op_a,
   output logic [DATA_W-1:0]        op_b
);

   logic [MEM_WORD_SIZE-1:0] word;

   // Capture the read data only when asked; otherwise hold so the operands stay stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         word <= '0;
      end else if (load) begin
         word <= word_in;
      end
   end

   assign op_a = word[DATA_W-1:0];
   assign op_b = word[MEM_WORD_SIZE-1:DATA_W];

endmodule

// File: rtl/operand_reader.sv
// Walks an inclusive address range, reading one 64-bit word at a time and
// presenting each as an operand pair on a valid/ready handshake.
// Every word costs fetch, capture and present cycles; the address never wraps.
module operand_reader
   import calculator_pkg::*;
(
   input  logic             clk_i,
   input  logic             rst_i,
   operand_reader_if.slave  bus
);

   reader_state_t     state;
   logic [ADDR_W-1:0] cur_addr;
   logic [ADDR_W-1:0] end_addr;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic              valid;
   logic              done;
   logic              err;
   logic              load_word;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;

   // Main controller: all outputs are registered and set on the transition into the state that shows them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= S_IDLE;
         cur_addr <= '0;
         end_addr <= '0;
         rd_en    <= 1'b0;
         rd_addr  <= '0;
         valid    <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               done <= 1'b0;
               err  <= 1'b0;
               if (bus.start_i) begin
                  if (bus.end_addr_i >= bus.start_addr_i) begin
                     cur_addr <= bus.start_addr_i;
                     end_addr <= bus.end_addr_i;
                     rd_en    <= 1'b1;
                     rd_addr  <= bus.start_addr_i;
                     state    <= S_FETCH;
                  end else begin
                     err  <= 1'b1;
                     done <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               rd_en   <= 1'b0;
               rd_addr <= '0;
               state   <= S_CAPTURE;
            end
            S_CAPTURE: begin
               valid <= 1'b1;
               state <= S_PRESENT;
            end
            S_PRESENT: begin
               if (bus.op_ready_i) begin
                  valid <= 1'b0;
                  if (cur_addr == end_addr) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     cur_addr <= cur_addr + 1'b1;
                     rd_en    <= 1'b1;
                     rd_addr  <= cur_addr + 1'b1;
                     state    <= S_FETCH;
                  end
               end
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign load_word = (state == S_CAPTURE);

   word_unpacker u_unpacker (
      .clk     (clk_i),
      .rst     (rst_i),
      .load    (load_word),
      .word_in (bus.mem_rdata_i),
      .op_a    (op_a),
      .op_b    (op_b)
   );

   assign bus.mem_rd_en_o = rd_en;
   assign bus.mem_addr_o  = rd_addr;
   assign bus.op_a_o      = op_a;
   assign bus.op_b_o      = op_b;
   assign bus.op_valid_o  = valid;
   assign bus.busy_o      = (state != S_IDLE);
   assign bus.done_o      = done;
   assign bus.err_o       = err;

endmodule

// File: tb/tb_operand_reader.sv
// Directed bench for operand_reader: a 1024-word memory model answers reads
// one cycle later, monitors log reads, handshakes and pulses.
module tb_operand_reader;
   import calculator_pkg::*;

   logic clk;
   logic rst;

   operand_reader_if bus ();

   operand_reader dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus.slave)
   );

   logic [MEM_WORD_SIZE-1:0] mem [0:1023];
   logic [ADDR_W-1:0]        rdLog[$];
   int hsCount;
   int doneCount;
   int errCount;
   int nAsserts;
   int nFails;

   // Free-running clock, 10 time units per cycle.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: data appears exactly one cycle after the read strobe, zero otherwise.
   always @(posedge clk) begin
      if (bus.mem_rd_en_o === 1'b1) bus.mem_rdata_i <= mem[bus.mem_addr_o];
      else bus.mem_rdata_i <= '0;
   end

   // Event monitors sampled at the active edge, where the DUT sees the same values.
   always @(posedge clk) begin
      if (bus.mem_rd_en_o === 1'b1) rdLog.push_back(bus.mem_addr_o);
      if (bus.op_valid_o === 1'b1 && bus.op_ready_i === 1'b1 && rst === 1'b0) hsCount++;
      if (bus.done_o === 1'b1) doneCount++;
      if (bus.err_o === 1'b1) errCount++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nAsserts++;
      assert (obs === exp) else begin
         nFails++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic [ADDR_W-1:0] s, input logic [ADDR_W-1:0] e);
      bus.start_i      = 1'b1;
      bus.start_addr_i = s;
      bus.end_addr_i   = e;
      tick();
      bus.start_i      = 1'b0;
   endtask

   task automatic waitValid(input string tag, input int bound);
      for (int i = 0; i < bound && bus.op_valid_o !== 1'b1; i++) tick();
      checkOutput(tag, 64'(bus.op_valid_o), 64'd1);
   endtask

   task automatic waitDone(input string tag, input int bound);
      for (int i = 0; i < bound && bus.done_o !== 1'b1; i++) tick();
      checkOutput(tag, 64'(bus.done_o), 64'd1);
   endtask

   int rdSnap;
   int hsSnap;
   int doneSnap;
   int errSnap;

   // Directed test sequence.
   initial begin
      nAsserts = 0;
      nFails   = 0;
      hsCount  = 0;
      doneCount = 0;
      errCount = 0;
      for (int i = 0; i < 1024; i++) mem[i] = {32'h5A5A_0000 + 32'(i), 32'hA5A5_0000 + 32'(i)};
      mem[5] = 64'hDEAD_BEEF_0000_0001;
      bus.start_i      = 1'b0;
      bus.start_addr_i = '0;
      bus.end_addr_i   = '0;
      bus.op_ready_i   = 1'b1;
      bus.mem_rdata_i  = '0;

      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      checkOutput("rst_state", 64'(dut.state), 64'(S_IDLE));
      checkOutput("rst_valid", 64'(bus.op_valid_o), 64'd0);
      checkOutput("rst_busy", 64'(bus.busy_o), 64'd0);
      checkOutput("rst_done", 64'(bus.done_o), 64'd0);
      checkOutput("rst_err", 64'(bus.err_o), 64'd0);
      checkOutput("rst_rden", 64'(bus.mem_rd_en_o), 64'd0);
      checkOutput("rst_opa", 64'(bus.op_a_o), 64'd0);
      checkOutput("rst_opb", 64'(bus.op_b_o), 64'd0);

      // Single word with exact cycle latency.
      $display("[TB] single word");
      rdSnap = rdLog.size(); hsSnap = hsCount; doneSnap = doneCount;
      applyStimulus(10'd5, 10'd5);
      checkOutput("t1_fetch_rden", 64'(bus.mem_rd_en_o), 64'd1);
      checkOutput("t1_fetch_addr", 64'(bus.mem_addr_o), 64'd5);
      checkOutput("t1_busy", 64'(bus.busy_o), 64'd1);
      tick();
      checkOutput("t1_capture_rden", 64'(bus.mem_rd_en_o), 64'd0);
      checkOutput("t1_capture_valid", 64'(bus.op_valid_o), 64'd0);
      tick();
      checkOutput("t1_valid", 64'(bus.op_valid_o), 64'd1);
      checkOutput("t1_opa", 64'(bus.op_a_o), 64'h0000_0001);
      checkOutput("t1_opb", 64'(bus.op_b_o), 64'hDEAD_BEEF);
      tick();
      checkOutput("t1_done", 64'(bus.done_o), 64'd1);
      checkOutput("t1_valid_off", 64'(bus.op_valid_o), 64'd0);
      tick();
      checkOutput("t1_done_off", 64'(bus.done_o), 64'd0);
      checkOutput("t1_busy_off", 64'(bus.busy_o), 64'd0);
      checkOutput("t1_reads", 64'(rdLog.size() - rdSnap), 64'd1);
      checkOutput("t1_read_addr", 64'(rdLog[rdSnap]), 64'd5);
      checkOutput("t1_hs", 64'(hsCount - hsSnap), 64'd1);
      checkOutput("t1_opa_hold", 64'(bus.op_a_o), 64'h0000_0001);

      // Range 0..3 with a 4-cycle stall on word 1.
      $display("[TB] range with backpressure");
      rdSnap = rdLog.size(); hsSnap = hsCount; doneSnap = doneCount;
      applyStimulus(10'd0, 10'd3);
      waitValid("t2_w0_timeout", 10);
      checkOutput("t2_w0_opa", 64'(bus.op_a_o), 64'hA5A5_0000);
      tick();
      bus.op_ready_i = 1'b0;
      waitValid("t2_w1_timeout", 10);
      begin
         int stallReads;
         stallReads = rdLog.size();
         for (int i = 0; i < 4; i++) begin
            checkOutput("t2_stall_valid", 64'(bus.op_valid_o), 64'd1);
            checkOutput("t2_stall_opa", 64'(bus.op_a_o), 64'hA5A5_0001);
            checkOutput("t2_stall_opb", 64'(bus.op_b_o), 64'h5A5A_0001);
            checkOutput("t2_stall_rden", 64'(bus.mem_rd_en_o), 64'd0);
            tick();
         end
         checkOutput("t2_stall_reads", 64'(rdLog.size() - stallReads), 64'd0);
      end
      bus.op_ready_i = 1'b1;
      waitDone("t2_done_timeout", 30);
      checkOutput("t2_opb_last", 64'(bus.op_b_o), 64'h5A5A_0003);
      checkOutput("t2_reads", 64'(rdLog.size() - rdSnap), 64'd4);
      for (int i = 0; i < 4; i++) checkOutput("t2_read_order", 64'(rdLog[rdSnap + i]), 64'(i));
      checkOutput("t2_hs", 64'(hsCount - hsSnap), 64'd4);
      tick();
      checkOutput("t2_done_count", 64'(doneCount - doneSnap), 64'd1);

      // Rejected range.
      $display("[TB] bad range");
      rdSnap = rdLog.size(); doneSnap = doneCount; errSnap = errCount;
      applyStimulus(10'd8, 10'd2);
      checkOutput("t3_err", 64'(bus.err_o), 64'd1);
      checkOutput("t3_done", 64'(bus.done_o), 64'd1);
      checkOutput("t3_busy", 64'(bus.busy_o), 64'd0);
      checkOutput("t3_rden", 64'(bus.mem_rd_en_o), 64'd0);
      tick();
      checkOutput("t3_err_off", 64'(bus.err_o), 64'd0);
      checkOutput("t3_done_off", 64'(bus.done_o), 64'd0);
      tick();
      checkOutput("t3_reads", 64'(rdLog.size() - rdSnap), 64'd0);
      checkOutput("t3_err_count", 64'(errCount - errSnap), 64'd1);
      checkOutput("t3_done_count", 64'(doneCount - doneSnap), 64'd1);

      // Reset while word 4 of 0..9 is presented.
      $display("[TB] mid-run reset");
      applyStimulus(10'd0, 10'd9);
      for (int w = 0; w < 4; w++) begin
         waitValid("t4_word_timeout", 10);
         tick();
      end
      waitValid("t4_w4_timeout", 10);
      checkOutput("t4_w4_opa", 64'(bus.op_a_o), 64'hA5A5_0004);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      doneSnap = doneCount; rdSnap = rdLog.size();
      checkOutput("t4_state", 64'(dut.state), 64'(S_IDLE));
      checkOutput("t4_valid", 64'(bus.op_valid_o), 64'd0);
      checkOutput("t4_opa", 64'(bus.op_a_o), 64'd0);
      checkOutput("t4_opb", 64'(bus.op_b_o), 64'd0);
      checkOutput("t4_busy", 64'(bus.busy_o), 64'd0);
      checkOutput("t4_rden", 64'(bus.mem_rd_en_o), 64'd0);
      checkOutput("t4_addr", 64'(bus.mem_addr_o), 64'd0);
      checkOutput("t4_done", 64'(bus.done_o), 64'd0);
      for (int i = 0; i < 5; i++) tick();
      checkOutput("t4_no_done", 64'(doneCount - doneSnap), 64'd0);
      checkOutput("t4_no_reads", 64'(rdLog.size() - rdSnap), 64'd0);
      applyStimulus(10'd0, 10'd0);
      waitDone("t4_restart_timeout", 10);
      checkOutput("t4_restart_opa", 64'(bus.op_a_o), 64'hA5A5_0000);
      checkOutput("t4_restart_reads", 64'(rdLog.size() - rdSnap), 64'd1);
      tick();

      // Top of the address space.
      $display("[TB] top of address space");
      rdSnap = rdLog.size(); doneSnap = doneCount;
      applyStimulus(10'd1022, 10'd1023);
      waitDone("t5_done_timeout", 20);
      checkOutput("t5_opa", 64'(bus.op_a_o), 64'hA5A5_03FF);
      checkOutput("t5_opb", 64'(bus.op_b_o), 64'h5A5A_03FF);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("t5_reads", 64'(rdLog.size() - rdSnap), 64'd2);
      checkOutput("t5_read0", 64'(rdLog[rdSnap]), 64'd1022);
      checkOutput("t5_read1", 64'(rdLog[rdSnap + 1]), 64'd1023);
      checkOutput("t5_done_count", 64'(doneCount - doneSnap), 64'd1);
      checkOutput("t5_busy", 64'(bus.busy_o), 64'd0);

      // Start pulse while busy must be ignored.
      $display("[TB] start while busy");
      rdSnap = rdLog.size(); doneSnap = doneCount;
      applyStimulus(10'd0, 10'd1);
      tick();
      applyStimulus(10'd50, 10'd50);
      waitDone("t6_done_timeout", 20);
      checkOutput("t6_opa", 64'(bus.op_a_o), 64'hA5A5_0001);
      for (int i = 0; i < 6; i++) tick();
      checkOutput("t6_reads", 64'(rdLog.size() - rdSnap), 64'd2);
      checkOutput("t6_read0", 64'(rdLog[rdSnap]), 64'd0);
      checkOutput("t6_read1", 64'(rdLog[rdSnap + 1]), 64'd1);
      checkOutput("t6_done_count", 64'(doneCount - doneSnap), 64'd1);
      checkOutput("t6_busy", 64'(bus.busy_o), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
      $finish;
   end

endmodule
